// File: rtl/ca_pkg.sv
// Shared C/A code definitions: code length, G2 phase-selector tap pairs, acquisition states.
package ca_pkg;

  localparam int CODE_LEN = 1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DWELL  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  // G2 stage pair (1-based) whose XOR forms the delayed G2 for PRN 1..32
  localparam logic [3:0] G2_TAP_A [32] = '{
    4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd1, 4'd2,
    4'd3, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd4,
    4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4
  };
  localparam logic [3:0] G2_TAP_B [32] = '{
    4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd10, 4'd8, 4'd9,
    4'd10, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd3, 4'd6,
    4'd7, 4'd8, 4'd9, 4'd10, 4'd6, 4'd7, 4'd8, 4'd9
  };

endpackage

// File: rtl/ca_replica.sv
// Local C/A replica: G1/G2 LFSR pair with re-seed and advance; chip output is combinational
// from the current register state so it lines up with the chip being correlated.
module ca_replica
  import ca_pkg::*;
(
  input  logic       clock,
  input  logic       init_i,
  input  logic       adv_i,
  input  logic [4:0] prn_i,
  output logic       chip_o
);

  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;
  logic [3:0]  tap_a, tap_b;

  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (init_i) begin
      g1_d = '1;
      g2_d = '1;
    end else if (adv_i) begin
      g1_d = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
      g2_d = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    end
  end

  always_ff @(posedge clock) begin
    g1_q <= g1_d;
    g2_q <= g2_d;
  end

  assign tap_a  = G2_TAP_A[prn_i];
  assign tap_b  = G2_TAP_B[prn_i];
  assign chip_o = g1_q[10] ^ g2_q[tap_a] ^ g2_q[tap_b];

endmodule

// File: rtl/ca_code_acquire.sv
// Serial slip-and-dwell C/A code acquisition over all 1023 phases of one PRN.
// Define CA_ACQ_TRACK_EN to keep dwelling after lock and resume the search on loss of lock.
module ca_code_acquire
  import ca_pkg::*;
#(
  parameter int DWELL_LEN  = 1023,
  parameter int THRESH     = 512,
  parameter int LOSS_COUNT = 3,
  parameter int ACC_W      = 13
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [4:0]              prn,
  input  logic                    chip_valid,
  input  logic                    chip_in,
  output logic                    busy,
  output logic                    locked,
  output logic                    fail,
  output logic [9:0]              code_phase,
  output logic signed [ACC_W-1:0] corr,
  output logic                    corr_valid,
  output logic                    polarity
);

  localparam logic [11:0]              CNT_LAST   = 12'(DWELL_LEN - 1);
  localparam logic [9:0]               PHASE_LAST = 10'(CODE_LEN - 1);
  localparam logic signed [ACC_W-1:0]  THR        = ACC_W'(THRESH);

  function automatic logic over_thresh(input logic signed [ACC_W-1:0] v);
    return (v >= THR) || (v <= -THR);
  endfunction

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_next;
  logic signed [ACC_W-1:0] corr_q, corr_d;
  logic [11:0]             cnt_q, cnt_d;
  logic [9:0]              phase_q, phase_d, phase_nxt, base;
  logic [4:0]              prn_q, prn_d;
  logic                    cv_q, cv_d, pol_q, pol_d;
  logic                    locked_q, locked_d, fail_q, fail_d, busy_q, busy_d;
  logic                    rep_init, rep_adv, rep_chip, dwelling;

`ifdef CA_ACQ_TRACK_EN
  localparam int                MISS_W    = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [9:0]        base_q, base_d;
  assign base     = base_q;
  assign dwelling = (state_q == ST_DWELL) || (state_q == ST_LOCKED);
`else
  assign base     = '0;
  assign dwelling = (state_q == ST_DWELL);
`endif

  ca_replica u_replica (
    .clock  (clock),
    .init_i (rep_init),
    .adv_i  (rep_adv),
    .prn_i  (prn_q),
    .chip_o (rep_chip)
  );

  assign acc_next  = (chip_in == rep_chip) ? acc_q + ACC_W'(1) : acc_q - ACC_W'(1);
  // Search fails when the next candidate would revisit the phase the search started from
  assign phase_nxt = (phase_q == PHASE_LAST) ? '0 : phase_q + 10'd1;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    corr_d   = corr_q;
    cv_d     = 1'b0;
    pol_d    = pol_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    busy_d   = busy_q;
    prn_d    = prn_q;
    rep_init = 1'b0;
    rep_adv  = 1'b0;
`ifdef CA_ACQ_TRACK_EN
    miss_d   = miss_q;
    base_d   = base_q;
`endif
    if (start) begin
      prn_d    = prn;
      rep_init = 1'b1;
      acc_d    = '0;
      cnt_d    = '0;
      phase_d  = '0;
      pol_d    = 1'b0;
      locked_d = 1'b0;
      fail_d   = 1'b0;
      busy_d   = 1'b1;
      state_d  = ST_DWELL;
`ifdef CA_ACQ_TRACK_EN
      miss_d   = '0;
      base_d   = '0;
`endif
    end else if (chip_valid) begin
      if (state_q == ST_SLIP) begin
        state_d = ST_DWELL;
      end else if (dwelling) begin
        rep_adv = 1'b1;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 12'd1;
          acc_d = acc_next;
        end else begin
          cnt_d  = '0;
          acc_d  = '0;
          corr_d = acc_next;
          cv_d   = 1'b1;
          if (state_q == ST_DWELL) begin
            if (over_thresh(acc_next)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              busy_d   = 1'b0;
              pol_d    = acc_next[ACC_W-1];
            end else if (phase_nxt == base) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              phase_d = phase_nxt;
              state_d = ST_SLIP;
            end
          end
`ifdef CA_ACQ_TRACK_EN
          else if (over_thresh(acc_next)) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            miss_d   = '0;
            locked_d = 1'b0;
            busy_d   = 1'b1;
            base_d   = phase_q;
            phase_d  = phase_nxt;
            state_d  = ST_SLIP;
          end else begin
            miss_d = miss_q + 1'b1;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      corr_q   <= '0;
      cv_q     <= 1'b0;
      pol_q    <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CA_ACQ_TRACK_EN
      miss_q   <= '0;
      base_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      corr_q   <= corr_d;
      cv_q     <= cv_d;
      pol_q    <= pol_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
      busy_q   <= busy_d;
`ifdef CA_ACQ_TRACK_EN
      miss_q   <= miss_d;
      base_q   <= base_d;
`endif
    end
    acc_q <= acc_d;
    cnt_q <= cnt_d;
    prn_q <= prn_d;
  end

  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign code_phase = phase_q;
  assign corr       = corr_q;
  assign corr_valid = cv_q;
  assign polarity   = pol_q;

endmodule

// File: tb/tb_ca_code_acquire.sv
// Scoreboard bench for ca_code_acquire: directed chip streams, expected dwell results queued
// at stimulus time and popped by a monitor on every corr_valid.
module tb_ca_code_acquire;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, start, chip_valid, chip_in;
  logic [4:0]        prn;
  logic              busy, locked, fail, corr_valid, polarity;
  logic [9:0]        code_phase;
  logic signed [12:0] corr;

  logic              reset_n_f, start_f, chip_valid_f, chip_in_f;
  logic [4:0]        prn_f;
  logic              busy_f, locked_f, fail_f, corr_valid_f, polarity_f;
  logic [9:0]        code_phase_f;
  logic signed [12:0] corr_f;

  ca_code_acquire u_dut (
    .clock(clk), .reset_n(reset_n), .start(start), .prn(prn),
    .chip_valid(chip_valid), .chip_in(chip_in),
    .busy(busy), .locked(locked), .fail(fail), .code_phase(code_phase),
    .corr(corr), .corr_valid(corr_valid), .polarity(polarity)
  );

  // One-chip dwells with an unreachable threshold: exercises the exhaustive-search failure quickly
  ca_code_acquire #(.DWELL_LEN(1), .THRESH(2)) u_dut_f (
    .clock(clk), .reset_n(reset_n_f), .start(start_f), .prn(prn_f),
    .chip_valid(chip_valid_f), .chip_in(chip_in_f),
    .busy(busy_f), .locked(locked_f), .fail(fail_f), .code_phase(code_phase_f),
    .corr(corr_f), .corr_valid(corr_valid_f), .polarity(polarity_f)
  );

  // mode 0: exact corr, 1: corr in {-1,-65,+63}, 2: |corr| below lock threshold
  typedef struct {
    int mode;
    int corr;
    bit lk;
    int ph;
    bit pol;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   c1[1023];
  bit   c3[1023];

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input int m, input int c, input bit l, input int p, input bit po);
    exp_t x;
    x.mode = m; x.corr = c; x.lk = l; x.ph = p; x.pol = po;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bit b, input int gap);
    chip_valid = 1'b1;
    chip_in    = b;
    tick();
    chip_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_start(input logic [4:0] p);
    start = 1'b1;
    prn   = p;
    chip_valid = 1'b1;
    chip_in    = 1'b1;
    tick();
    start      = 1'b0;
    chip_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    repeat (4) tick();
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_corr_valid"}, corr_valid, 0);
    chk({tag, "_polarity"}, polarity, 0);
    chk({tag, "_code_phase"}, code_phase, 0);
    chk({tag, "_corr"}, corr, 0);
  endtask

  always @(negedge clk) begin
    if (corr_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_corr_valid: got corr=%0d, expected no dwell result", corr);
      end else begin
        e = sb.pop_front();
        if (e.mode == 0) begin
          chk("corr", corr, e.corr);
        end else if (e.mode == 1) begin
          n_cmp++;
          if (!(corr == -13'sd1 || corr == -13'sd65 || corr == 13'sd63)) begin
            n_bad++;
            $display("FAIL corr_sidelobe: got %0d, expected one of -1/-65/63", corr);
          end
        end else begin
          n_cmp++;
          if (corr >= 13'sd512 || corr <= -13'sd512) begin
            n_bad++;
            $display("FAIL corr_below_thresh: got %0d, expected |corr| < 512", corr);
          end
        end
        chk("dwell_locked", locked, e.lk);
        chk("dwell_code_phase", code_phase, e.ph);
        chk("dwell_polarity", polarity, e.pol);
      end
    end
  end

  initial begin
    logic [10:1] g1, g2;
    int          n;
    reset_n = 1'b0; start = 1'b0; prn = '0; chip_valid = 1'b0; chip_in = 1'b0;
    reset_n_f = 1'b0; start_f = 1'b0; prn_f = '0; chip_valid_f = 1'b0; chip_in_f = 1'b0;

    // Reference PRN1 (taps 2,6) and PRN3 (taps 4,8) sequences from chip 0
    g1 = '1;
    g2 = '1;
    for (int i = 0; i < 1023; i++) begin
      c1[i] = g1[10] ^ g2[2] ^ g2[6];
      c3[i] = g1[10] ^ g2[4] ^ g2[8];
      g1 = {g1[9:1], g1[3] ^ g1[10]};
      g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
    end

    repeat (2) tick();
    chk_zero("reset");
    reset_n   = 1'b1;
    reset_n_f = 1'b1;
    tick();

    // PRN1 aligned at chip 0
    do_start(5'd0);
    chk("t1_busy_searching", busy, 1);
    push(0, 1023, 1'b1, 0, 1'b0);
    for (int i = 0; i < 1023; i++) feed(c1[i], 0);
    drain("t1_pending");
    chk("t1_busy_after_lock", busy, 0);
    chk("t1_fail", fail, 0);

`ifdef CA_ACQ_TRACK_EN
    // Stream drops to zeros after lock: three -1 dwells, then search resumes at phase 1
    push(0, -1, 1'b1, 0, 1'b0);
    push(0, -1, 1'b1, 0, 1'b0);
    push(0, -1, 1'b0, 1, 1'b0);
    for (int i = 0; i < 3 * 1023; i++) feed(1'b0, 0);
    drain("trk_pending");
    chk("trk_busy", busy, 1);
    chk("trk_locked", locked, 0);
`endif

    // Five leading zeros: lock after five slips
    do_start(5'd0);
    push(2, 0, 1'b0, 1, 1'b0);
    for (int k = 1; k <= 4; k++) push(1, 0, 1'b0, k + 1, 1'b0);
    push(0, 1023, 1'b1, 5, 1'b0);
    for (int s = 0; s < 6143; s++) feed((s < 5) ? 1'b0 : c1[(s - 5) % 1023], 0);
    drain("t2_pending");
    chk("t2_busy", busy, 0);

    // Inverted stream locks with negative polarity
    do_start(5'd0);
    push(0, -1023, 1'b1, 0, 1'b1);
    for (int i = 0; i < 1023; i++) feed(~c1[i], 0);
    drain("t3_pending");

    // Reset mid-dwell, then a fresh PRN3 search
    do_start(5'd0);
    for (int i = 0; i < 500; i++) feed(c1[i], 0);
    reset_n = 1'b0;
    tick();
    chk_zero("midreset");
    tick();
    reset_n = 1'b1;
    tick();
    do_start(5'd2);
    push(0, 1023, 1'b1, 0, 1'b0);
    for (int i = 0; i < 1023; i++) feed(c3[i], 0);
    drain("t5_pending");

    // Sparse chip_valid, prn changed without start
    do_start(5'd2);
    prn = 5'd7;
    push(0, 1023, 1'b1, 0, 1'b0);
    for (int i = 0; i < 1023; i++) feed(c3[i], 2);
    drain("t5_sparse_pending");

    // Exhaustive search without lock: 1023 one-chip dwells + 1022 slips = 2045 chips
    start_f = 1'b1;
    prn_f   = 5'd0;
    tick();
    start_f = 1'b0;
    n = 0;
    while (!fail_f && n < 3000) begin
      chip_valid_f = 1'b1;
      chip_in_f    = 1'b0;
      tick();
      chip_valid_f = 1'b0;
      n++;
    end
    chk("fail_chip_count", n, 2045);
    chk("fail_flag", fail_f, 1);
    chk("fail_code_phase", code_phase_f, 1022);
    chk("fail_busy", busy_f, 0);
    chk("fail_locked", locked_f, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
